// File: rtl/xgmii_pkg.sv
// XGMII character codes, link-mode encodings and a saturating counter helper.
// Shared by the link model and its bench; holds no logic of its own.
package xgmii_pkg;

    localparam logic [7:0]  IDLE    = 8'h07;
    localparam logic [7:0]  START   = 8'hFB;
    localparam logic [7:0]  TERM    = 8'hFD;
    localparam logic [7:0]  ERROR   = 8'hFE;
    // Local-fault ordered set for one 4-lane group, lane 0 in the low byte.
    localparam logic [31:0] LF_SEQ  = 32'h0100_009C;
    localparam logic [3:0]  LF_CTRL = 4'b0001;

    typedef enum logic [2:0] {
        MODE_PASS     = 3'd0,
        MODE_FAULT    = 3'd1,
        MODE_IDLE     = 3'd2,
        MODE_PASS_ERR = 3'd3,
        MODE_DRAIN    = 3'd4
    } link_mode_e;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/xgmii_delay_line.sv
// Shift-register pipeline, DEPTH cycles from din to dout; every stage resets to rst_val.
// No backpressure: a new word enters every cycle.
module xgmii_delay_line #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 2
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/xgmii_link_model.sv
// XGMII loopback channel with frame-aware mode switching, error injection and counters.
// Latency DELAY cycles txd->rxd, status leads data by DELAY-1; no backpressure.
module xgmii_link_model
    import xgmii_pkg::*;
#(
    parameter int LANES = 8,
    parameter int DELAY = 2
) (
    input  logic               clk_156m25,
    input  logic               reset_156m25_n,
    input  logic [LANES*8-1:0] xgmii_txd_i,
    input  logic [LANES-1:0]   xgmii_txc_i,
    input  logic [1:0]         mode_i,
    input  logic               err_inject_i,
    output logic [LANES*8-1:0] xgmii_rxd_o,
    output logic [LANES-1:0]   xgmii_rxc_o,
    output logic               link_up_o,
    output logic [15:0]        frame_cnt_o,
    output logic [15:0]        err_cnt_o
);

    link_mode_e         state_q, state_d, req_mode;
    logic               in_frame_q, in_frame_d;
    logic               sop_q, armed_q, armed_d;
    logic [15:0]        frame_cnt_q, err_cnt_q;
    logic [1:0]         n_start;
    logic               term_lane0, inject, forwarding;
    logic [LANES*8-1:0] col_dat;
    logic [LANES-1:0]   col_ctl;
    logic [LANES*9-1:0] pipe_out;

    // Lanes are scanned in order so a /T/ followed by a later /S/ leaves the frame open.
    always_comb begin
        in_frame_d = in_frame_q;
        n_start    = 2'd0;
        for (int n = 0; n < LANES; n++) begin
            if (xgmii_txc_i[n] && xgmii_txd_i[8*n +: 8] == START && (n == 0 || n == 4)) begin
                in_frame_d = 1'b1;
                n_start    = n_start + 2'd1;
            end
            if (xgmii_txc_i[n] && xgmii_txd_i[8*n +: 8] == TERM) in_frame_d = 1'b0;
        end
    end

    assign term_lane0 = xgmii_txc_i[0] && (xgmii_txd_i[7:0] == TERM);
    assign inject     = (state_q == MODE_PASS_ERR) && armed_q && sop_q && !term_lane0;
    assign forwarding = (state_q == MODE_PASS) || (state_q == MODE_PASS_ERR) || (state_q == MODE_DRAIN);
    assign req_mode   = link_mode_e'({1'b0, mode_i});

    always_comb begin
        state_d = state_q;
        if (state_q == MODE_DRAIN) begin
            if (!in_frame_d) state_d = req_mode;
        end else if (req_mode != state_q) begin
            if (!in_frame_d ||
                (state_q == MODE_PASS     && req_mode == MODE_PASS_ERR) ||
                (state_q == MODE_PASS_ERR && req_mode == MODE_PASS))
                state_d = req_mode;
            else
                state_d = MODE_DRAIN;
        end
    end

    always_comb begin
        armed_d = armed_q;
        if (state_d != MODE_PASS_ERR)                   armed_d = 1'b0;
        else if (inject)                                armed_d = 1'b0;
        else if (err_inject_i && state_q == MODE_PASS_ERR) armed_d = 1'b1;
    end

    always_comb begin
        col_dat = xgmii_txd_i;
        col_ctl = xgmii_txc_i;
        case (state_q)
            MODE_FAULT: begin
                col_dat = {(LANES/4){LF_SEQ}};
                col_ctl = {(LANES/4){LF_CTRL}};
            end
            MODE_IDLE: begin
                col_dat = {LANES{IDLE}};
                col_ctl = {LANES{1'b1}};
            end
            default: begin
                if (inject) begin
                    col_dat[7:0] = ERROR;
                    col_ctl[0]   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q     <= MODE_PASS;
            in_frame_q  <= 1'b0;
            sop_q       <= 1'b0;
            armed_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            sop_q      <= in_frame_d && (n_start != 2'd0);
            armed_q    <= armed_d;
            if (forwarding) frame_cnt_q <= sat_add(frame_cnt_q, n_start);
            if (inject)     err_cnt_q   <= sat_add(err_cnt_q, 2'd1);
        end
    end

    xgmii_delay_line #(
        .WIDTH (LANES*9),
        .DEPTH (DELAY)
    ) u_delay (
        .core_clk (clk_156m25),
        .arst_n   (reset_156m25_n),
        .rst_val  ({{LANES{1'b1}}, {LANES{IDLE}}}),
        .din      ({col_ctl, col_dat}),
        .dout     (pipe_out)
    );

    assign xgmii_rxd_o = pipe_out[LANES*8-1:0];
    assign xgmii_rxc_o = pipe_out[LANES*9-1:LANES*8];
    assign link_up_o   = (state_q == MODE_PASS) || (state_q == MODE_PASS_ERR);
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_xgmii_link_model.sv
// Directed bench for xgmii_link_model (LANES 8, DELAY 3): every output column is
// compared against a hand-built expected column queued DELAY cycles earlier.
module tb_xgmii_link_model;

    localparam int DELAY = 3;
    localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] LF_D   = 64'h0100_009C_0100_009C;
    localparam logic [7:0]  LF_C   = 8'h11;
    localparam logic [63:0] SOP_D  = 64'hD555_5555_5555_55FB;
    localparam logic [7:0]  SOP_C  = 8'h01;
    localparam logic [63:0] EOP_D  = 64'h0707_0707_0707_07FD;
    localparam logic [63:0] L4S_D  = 64'h3322_11FB_0707_0707;
    localparam logic [7:0]  L4S_C  = 8'h1F;
    localparam logic [63:0] DBL_D  = 64'h7766_55FB_FD22_11FB;
    localparam logic [7:0]  DBL_C  = 8'h19;

    typedef struct { logic [63:0] d; logic [7:0] c; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] txd, rxd;
    logic [7:0]  txc, rxc;
    logic [1:0]  mode, mode_r;
    logic        err_inject, err_r;
    logic        link_up;
    logic [15:0] frame_cnt, err_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    xgmii_link_model #(.LANES(8), .DELAY(DELAY)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .xgmii_txd_i    (txd),
        .xgmii_txc_i    (txc),
        .mode_i         (mode),
        .err_inject_i   (err_inject),
        .xgmii_rxd_o    (rxd),
        .xgmii_rxc_o    (rxc),
        .link_up_o      (link_up),
        .frame_cnt_o    (frame_cnt),
        .err_cnt_o      (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dcol(input int k);
        return {8{8'(k)}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Checks the column due out now, then drives the next one and queues its expectation.
    task automatic col(input logic [63:0] d, input logic [7:0] c,
                       input logic [63:0] ed, input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() >= DELAY) begin
            e = exp_q.pop_front();
            chk("rxd", rxd, e.d);
            chk("rxc", 64'(rxc), 64'(e.c));
        end
        txd = d; txc = c; mode = mode_r; err_inject = err_r;
        exp_q.push_back('{d: ed, c: ec});
    endtask

    task automatic idles(input int n);
        repeat (n) col(IDLE_D, IDLE_C, IDLE_D, IDLE_C);
    endtask

    task automatic restart_queue();
        exp_q.delete();
        repeat (DELAY) exp_q.push_back('{d: IDLE_D, c: IDLE_C});
    endtask

    // 64-byte frame: /S/ column, eight data columns, /T/ column.
    task automatic send_frame(input int seed, input bit inj, input bit blank);
        logic [63:0] ed;
        col(SOP_D, SOP_C, blank ? IDLE_D : SOP_D, blank ? IDLE_C : SOP_C);
        for (int i = 0; i < 8; i++) begin
            ed = dcol(seed + i);
            if (inj && i == 0) ed[7:0] = 8'hFE;
            col(dcol(seed + i), 8'h00, blank ? IDLE_D : ed,
                blank ? IDLE_C : ((inj && i == 0) ? 8'h01 : 8'h00));
        end
        col(EOP_D, IDLE_C, blank ? IDLE_D : EOP_D, IDLE_C);
    endtask

    initial begin
        rst_n = 1'b0; txd = IDLE_D; txc = IDLE_C;
        mode = 2'd0; mode_r = 2'd0; err_inject = 1'b0; err_r = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rxd", rxd, IDLE_D);
        chk("reset_rxc", 64'(rxc), 64'(IDLE_C));
        chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        chk("reset_link_up", 64'(link_up), 64'd1);
        rst_n = 1'b1;
        restart_queue();

        // Pass-through
        idles(2);
        send_frame(16, 1'b0, 1'b0);
        idles(4);
        chk("pass_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("pass_link_up", 64'(link_up), 64'd1);

        // Injection: a two-cycle pulse arms once; only frame 1 is hit
        mode_r = 2'd3;
        idles(2);
        err_r = 1'b1;
        idles(2);
        err_r = 1'b0;
        idles(1);
        send_frame(32, 1'b1, 1'b0);
        idles(2);
        send_frame(48, 1'b0, 1'b0);
        idles(4);
        chk("inj_err_cnt", 64'(err_cnt), 64'd1);
        chk("inj_frame_cnt", 64'(frame_cnt), 64'd3);
        mode_r = 2'd0;
        idles(2);

        // Drain into FAULT
        col(SOP_D, SOP_C, SOP_D, SOP_C);
        col(dcol(64), 8'h00, dcol(64), 8'h00);
        mode_r = 2'd1;
        col(dcol(65), 8'h00, dcol(65), 8'h00);
        col(dcol(66), 8'h00, dcol(66), 8'h00);
        col(EOP_D, IDLE_C, EOP_D, IDLE_C);
        repeat (3) col(IDLE_D, IDLE_C, LF_D, LF_C);
        chk("fault_link_up", 64'(link_up), 64'd0);
        chk("drain_frame_cnt", 64'(frame_cnt), 64'd4);
        mode_r = 2'd0;
        col(IDLE_D, IDLE_C, LF_D, LF_C);
        idles(4);
        chk("unfault_link_up", 64'(link_up), 64'd1);

        // Lane-4 start with an IDLE request in the same column: drains first
        mode_r = 2'd2;
        col(L4S_D, L4S_C, L4S_D, L4S_C);
        col(dcol(80), 8'h00, dcol(80), 8'h00);
        col(EOP_D, IDLE_C, EOP_D, IDLE_C);
        idles(2);
        send_frame(96, 1'b0, 1'b1);
        idles(4);
        chk("l4_frame_cnt", 64'(frame_cnt), 64'd5);
        chk("idle_link_up", 64'(link_up), 64'd0);
        mode_r = 2'd0;
        idles(4);

        // Reset mid-frame: outputs drop to Idle at once; the tail passes unchanged
        col(SOP_D, SOP_C, SOP_D, SOP_C);
        col(dcol(112), 8'h00, dcol(112), 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b0; txd = IDLE_D; txc = IDLE_C;
        #1;
        chk("arst_rxd", rxd, IDLE_D);
        chk("arst_rxc", 64'(rxc), 64'(IDLE_C));
        chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        restart_queue();
        col(dcol(113), 8'h00, dcol(113), 8'h00);
        col(dcol(114), 8'h00, dcol(114), 8'h00);
        col(EOP_D, IDLE_C, EOP_D, IDLE_C);
        idles(4);
        chk("tail_frame_cnt", 64'(frame_cnt), 64'd0);

        // Saturation: two /S/ per column
        repeat (32767) col(DBL_D, DBL_C, DBL_D, DBL_C);
        idles(3);
        chk("sat_pre", 64'(frame_cnt), 64'hFFFE);
        col(DBL_D, DBL_C, DBL_D, DBL_C);
        idles(3);
        chk("sat_hit", 64'(frame_cnt), 64'hFFFF);
        repeat (3) col(DBL_D, DBL_C, DBL_D, DBL_C);
        idles(4);
        chk("sat_hold", 64'(frame_cnt), 64'hFFFF);
        chk("sat_err_cnt", 64'(err_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmii_link_model.md
# xgmii_link_model

Parameterised, synthesisable XGMII link model between the MAC transmit and receive XGMII ports. It replaces a hard-wired txd/txc to rxd/rxc loopback with a configurable-latency channel. In one clock domain it adds frame-aware mode switching (pass, local fault, forced idle, pass with error injection), frame and error counters, and link status. Each unit test bench instantiates it next to `xge_mac`, and each bench instance drives the loopback `rxd`/`rxc` pair.

## Interface
- `LANES`, default 8: XGMII byte lanes per column; legal values 4 or 8.
- `DELAY`, default 2: channel latency in clock cycles; legal range 1..16.
- `clk_156m25`, in, 1: single clock; all logic on the rising edge.
- `reset_156m25_n`, in, 1: reset, asynchronous, active-low.
- `xgmii_txd_i`, in, LANES*8: transmit data column from the MAC; lane n is bits [8n+7:8n].
- `xgmii_txc_i`, in, LANES: transmit control flags; bit n belongs to lane n.
- `mode_i`, in, 2: requested mode. 0 = PASS, 1 = FAULT, 2 = IDLE, 3 = PASS_ERR.
- `err_inject_i`, in, 1: single-cycle pulse that arms a one-shot error injection.
- `xgmii_rxd_o`, out, LANES*8: data column delivered to the MAC receive side.
- `xgmii_rxc_o`, out, LANES: control flags delivered to the MAC receive side.
- `link_up_o`, out, 1: 1 while the active mode is PASS or PASS_ERR.
- `frame_cnt_o`, out, 16: count of `/S/` characters forwarded; saturates at 16'hFFFF.
- `err_cnt_o`, out, 16: count of injected `/E/` characters; saturates at 16'hFFFF.

## Operation
**Character codes**
- Idle 8'h07, Start 8'hFB, Terminate 8'hFD, Error 8'hFE; each has its ctrl bit = 1.
- Local-fault ordered set, per 4-lane group: lane0 8'h9C ctrl 1; lanes1..3 8'h00, 8'h00, 8'h01 ctrl 0.

**Frame tracking**
- `in_frame` sets on `/S/` in lane 0, or in lane 4 when LANES = 8.
- It clears on `/T/` in any lane.
- A column that contains both `/T/` and a later `/S/` leaves `in_frame` set.

**Active-mode state machine** (states PASS, PASS_ERR, FAULT, IDLE, DRAIN)
- A change of `mode_i` takes effect only when `in_frame` is 0 for the current column.
- If the change is requested while `in_frame` = 1, the FSM enters DRAIN.
  - DRAIN forwards columns unchanged until the column carrying `/T/`.
  - The next cycle enters the state requested at that time.
- A PASS to PASS_ERR change, or the reverse, never needs DRAIN and takes effect immediately.

**Per-state output column**
- PASS / DRAIN: input column unchanged.
- FAULT: local-fault ordered set in every 4-lane group.
- IDLE: all lanes Idle.
- PASS_ERR: input column, with injection applied.

**Injection**
- `err_inject_i` sets `armed` only while the active state is PASS_ERR; otherwise the pulse is ignored.
- When `armed` = 1 and `in_frame` = 1, the first column after the `/S/` column is modified: lane 0 becomes `/E/` ctrl 1.
- If that column's lane 0 carries `/T/`, injection defers to the next frame.
- On injection, `armed` clears and `err_cnt_o` increments.
- Leaving PASS_ERR clears `armed`.

**Frame counter**
- `frame_cnt_o` increments once per forwarded `/S/` in PASS, PASS_ERR or DRAIN.

## Timing
- The processed column passes through a `DELAY`-stage register pipeline.
- `xgmii_rxd_o`/`xgmii_rxc_o` at cycle t+DELAY reflect the input sampled at cycle t.
- The mode-dependent substitution is applied at stage 1. Counters and `link_up_o` update at stage 1, so they lead the output by DELAY-1 cycles.
- Reset values:
  - every pipeline stage and the outputs: Idle on all lanes (rxd = {LANES{8'h07}}, rxc = all ones);
  - active state PASS, `link_up_o` = 1;
  - counters 0, `armed` = 0, `in_frame` = 0.
- Reset asserted mid-frame: outputs go to Idle asynchronously. After release, the remainder of the truncated frame, which has no `/S/`, passes unchanged.
- `err_inject_i` arriving while `armed` = 1 is a no-op; injections never queue.
- Counters hold at 16'hFFFF; they never wrap.

## Structure
- Package `xgmii_pkg` holds:
  - character constants: IDLE, START, TERM, ERROR, LF_SEQ;
  - enum `link_mode_e` covering the four `mode_i` encodings plus DRAIN for the state register.
- One sub-module, `xgmii_delay_line`, parameterised by width and DELAY, with an asynchronous active-low reset value port; it is the shift-register pipeline.
- The top module holds the FSM, frame tracking, injection and counters.

## Test plan
- **Pass-through:** LANES 8, DELAY 3, mode 0; a 64-byte frame with `/S/` in lane 0. Output equals the input shifted by exactly 3 cycles; `frame_cnt_o` = 1; `link_up_o` stays 1.
- **Reset idle:** hold `reset_156m25_n` low. Output is 64'h0707070707070707 with rxc 8'hFF; both counters read 0.
- **Injection:** mode 3, pulse `err_inject_i`, then send two frames. Only the second column of frame 1 has lane 0 = 8'hFE, ctrl 1; frame 2 is unmodified; `err_cnt_o` = 1.
- **Drain:** mid-frame, switch `mode_i` to 1. The frame completes intact through `/T/`. Next column: lane0 8'h9C ctrl 1, lanes 1..3 00 00 01 (same pattern in lanes 4..7); `link_up_o` = 0.
- **Lane-4 start, LANES 8:** `/S/` in lane 4 is counted; a mode-2 request in the same cycle enters DRAIN, not IDLE.
- **Saturation:** preload via 65 537 short frames, or force the counter. `frame_cnt_o` holds 16'hFFFF.
